// File: rtl/data_sram_responder.sv
// Responder for the core's data SRAM-like port: byte-writable RAM plus a small
// config window (LED, numeric display, timer, synchronized switches), 1-cycle read latency.
module data_sram_responder #(
   parameter int unsigned RAM_AW  = 14,
   parameter logic [15:0] CONF_HI = 16'hbfaf
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   input  logic [15:0] switch_in,
   output logic [15:0] led_out,
   output logic [31:0] num_out,
   output logic [31:0] timer_out
);

   localparam int unsigned DEPTH = 1 << RAM_AW;

   localparam logic [15:0] OFF_LED    = 16'hf000;
   localparam logic [15:0] OFF_NUM    = 16'hf010;
   localparam logic [15:0] OFF_TIMER  = 16'he000;
   localparam logic [15:0] OFF_SWITCH = 16'hf020;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
      logic [31:0] res;
      res = old_w;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction

   logic [31:0] mem_q [DEPTH];

   logic [31:0] rdata_q, rdata_d;
   logic [15:0] led_q, led_d;
   logic [31:0] num_q, num_d;
   logic [31:0] timer_q, timer_d;
   logic [15:0] sw_s1_q, sw_s2_q;

   logic              conf_c;
   logic              wr_req_c, rd_req_c;
   logic              sel_led_c, sel_num_c, sel_timer_c, sel_switch_c;
   logic [RAM_AW-1:0] ram_idx_c;
   logic [31:0]       conf_rdata_c;
   logic [31:0]       led_merged_c;

   // addr[1:0] are ignored: requests are word aligned
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^data_sram_addr[1:0];

   // Request decode
   always_comb begin
      conf_c       = (data_sram_addr[31:16] == CONF_HI);
      wr_req_c     = data_sram_en && (data_sram_wen != 4'h0);
      rd_req_c     = data_sram_en && (data_sram_wen == 4'h0);
      ram_idx_c    = data_sram_addr[RAM_AW+1:2];
      sel_led_c    = conf_c && (data_sram_addr[15:2] == OFF_LED[15:2]);
      sel_num_c    = conf_c && (data_sram_addr[15:2] == OFF_NUM[15:2]);
      sel_timer_c  = conf_c && (data_sram_addr[15:2] == OFF_TIMER[15:2]);
      sel_switch_c = conf_c && (data_sram_addr[15:2] == OFF_SWITCH[15:2]);
   end

   // Config-window read mux; unmapped offsets read as zero
   always_comb begin
      conf_rdata_c = 32'h0;
      if (sel_led_c)         conf_rdata_c = {16'h0, led_q};
      else if (sel_num_c)    conf_rdata_c = num_q;
      else if (sel_timer_c)  conf_rdata_c = timer_q;
      else if (sel_switch_c) conf_rdata_c = {16'h0, sw_s2_q};
   end

   // Next-state for registers; a timer write overrides that cycle's increment
   always_comb begin
      led_merged_c = byte_merge({16'h0, led_q}, data_sram_wdata, data_sram_wen);
      led_d   = led_q;
      num_d   = num_q;
      timer_d = timer_q + 32'd1;
      rdata_d = rdata_q;
      if (wr_req_c && sel_led_c)   led_d   = led_merged_c[15:0];
      if (wr_req_c && sel_num_c)   num_d   = byte_merge(num_q, data_sram_wdata, data_sram_wen);
      if (wr_req_c && sel_timer_c) timer_d = byte_merge(timer_q, data_sram_wdata, data_sram_wen);
      if (rd_req_c)                rdata_d = conf_c ? conf_rdata_c : mem_q[ram_idx_c];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= 32'h0;
         led_q   <= 16'h0;
         num_q   <= 32'h0;
         timer_q <= 32'h0;
         sw_s1_q <= 16'h0;
         sw_s2_q <= 16'h0;
      end else begin
         rdata_q <= rdata_d;
         led_q   <= led_d;
         num_q   <= num_d;
         timer_q <= timer_d;
         sw_s1_q <= switch_in;
         sw_s2_q <= sw_s1_q;
      end
   end

   // RAM contents are not reset; writes are dropped during reset cycles
   always_ff @(posedge clk) begin
      if (!rst && wr_req_c && !conf_c) begin
         for (int i = 0; i < 4; i++) begin
            if (data_sram_wen[i]) mem_q[ram_idx_c][8*i +: 8] <= data_sram_wdata[8*i +: 8];
         end
      end
   end

   assign data_sram_rdata = rdata_q;
   assign led_out         = led_q;
   assign num_out         = num_q;
   assign timer_out       = timer_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed self-checking bench for data_sram_responder.
module tb_data_sram_responder;

   logic        clk;
   logic        rst;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic [15:0] switch_in;
   logic [15:0] led_out;
   logic [31:0] num_out;
   logic [31:0] timer_out;

   int unsigned n_cmp;
   int unsigned n_err;

   data_sram_responder #(.RAM_AW(14), .CONF_HI(16'hbfaf)) dut (
      .clk             (clk),
      .rst             (rst),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .switch_in       (switch_in),
      .led_out         (led_out),
      .num_out         (num_out),
      .timer_out       (timer_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs are then driven/outputs sampled 1ns after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      data_sram_en  = 1'b0;
      data_sram_wen = 4'h0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
      data_sram_en    = 1'b1;
      data_sram_wen   = be;
      data_sram_addr  = addr;
      data_sram_wdata = data;
      tick();
      idle();
   endtask

   task automatic rd(input logic [31:0] addr);
      data_sram_en   = 1'b1;
      data_sram_wen  = 4'h0;
      data_sram_addr = addr;
      tick();
      idle();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      data_sram_en = 1'b0;
      data_sram_wen = 4'h0;
      data_sram_addr = 32'h0;
      data_sram_wdata = 32'h0;
      switch_in = 16'h0;
      tick();
      tick();
      check_val("reset_rdata", data_sram_rdata, 32'h0);
      check_val("reset_timer", timer_out, 32'h0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check_val("idle_rdata", data_sram_rdata, 32'h0);
      check_val("idle_led", {16'h0, led_out}, 32'h0);
      check_val("idle_num", num_out, 32'h0);
      check_val("idle_timer5", timer_out, 32'd5);

      // Byte-enable merge on RAM
      wr(32'h0000_0010, 32'h1122_3344, 4'hf);
      wr(32'h0000_0010, 32'hAABB_CCDD, 4'b0101);
      rd(32'h0000_0010);
      check_val("ram_merge", data_sram_rdata, 32'h11BB_33DD);
      tick();
      check_val("ram_hold_idle", data_sram_rdata, 32'h11BB_33DD);

      // Write then read next cycle, then back-to-back reads
      wr(32'h0000_0040, 32'h1111_1111, 4'hf);
      check_val("hold_after_wr", data_sram_rdata, 32'h11BB_33DD);
      rd(32'h0000_0040);
      check_val("wr_then_rd", data_sram_rdata, 32'h1111_1111);
      data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = 32'h0000_0010;
      tick();
      check_val("b2b_rd0", data_sram_rdata, 32'h11BB_33DD);
      data_sram_addr = 32'h0000_0040;
      tick();
      check_val("b2b_rd1", data_sram_rdata, 32'h1111_1111);
      idle();
      // Alias: upper index bits ignored (RAM_AW=14 -> bit 16 aliases)
      rd(32'h0001_0040);
      check_val("ram_alias", data_sram_rdata, 32'h1111_1111);

      // en=0 with wen set must not write
      data_sram_en = 1'b0; data_sram_wen = 4'hf; data_sram_addr = 32'h0000_0040;
      data_sram_wdata = 32'h0;
      tick();
      idle();
      rd(32'h0000_0040);
      check_val("no_wr_en0", data_sram_rdata, 32'h1111_1111);

      // LED and NUM
      wr(32'hbfaf_f000, 32'hFFFF_A5A5, 4'hf);
      check_val("led_wr", {16'h0, led_out}, 32'h0000_A5A5);
      rd(32'hbfaf_f000);
      check_val("led_rd", data_sram_rdata, 32'h0000_A5A5);
      wr(32'hbfaf_f010, 32'h7F00_0000, 4'b1000);
      check_val("num_wr", num_out, 32'h7F00_0000);
      wr(32'hbfaf_f010, 32'h0000_0012, 4'b0001);
      check_val("num_byte0", num_out, 32'h7F00_0012);
      rd(32'hbfaf_f010);
      check_val("num_rd", data_sram_rdata, 32'h7F00_0012);

      // Timer write and wrap
      wr(32'hbfaf_e000, 32'hFFFF_FFFE, 4'hf);
      check_val("timer_wr", timer_out, 32'hFFFF_FFFE);
      tick();
      check_val("timer_ff", timer_out, 32'hFFFF_FFFF);
      rd(32'hbfaf_e000);
      check_val("timer_wrap", timer_out, 32'h0);
      check_val("timer_rd", data_sram_rdata, 32'hFFFF_FFFF);

      // Switch synchronizer latency
      switch_in = 16'h00F0;
      tick();
      rd(32'hbfaf_f020);
      check_val("sw_old", data_sram_rdata, 32'h0);
      rd(32'hbfaf_f020);
      check_val("sw_new", data_sram_rdata, 32'h0000_00F0);

      // Read-only and unmapped offsets
      wr(32'hbfaf_f020, 32'hFFFF_FFFF, 4'hf);
      rd(32'hbfaf_f020);
      check_val("sw_ro", data_sram_rdata, 32'h0000_00F0);
      wr(32'hbfaf_1234, 32'hFFFF_FFFF, 4'hf);
      rd(32'hbfaf_1234);
      check_val("unmapped_rd", data_sram_rdata, 32'h0);
      check_val("unmapped_led", {16'h0, led_out}, 32'h0000_A5A5);
      check_val("unmapped_num", num_out, 32'h7F00_0012);

      // Reset coincident with a write: write dropped, registers cleared
      rd(32'h0000_0040);
      rst = 1'b1;
      data_sram_en = 1'b1; data_sram_wen = 4'hf;
      data_sram_addr = 32'h0000_0040; data_sram_wdata = 32'h0000_DEAD;
      tick();
      idle();
      check_val("rst_rdata", data_sram_rdata, 32'h0);
      check_val("rst_led", {16'h0, led_out}, 32'h0);
      check_val("rst_num", num_out, 32'h0);
      check_val("rst_timer", timer_out, 32'h0);
      rst = 1'b0;
      rd(32'h0000_0040);
      check_val("rst_wr_dropped", data_sram_rdata, 32'h1111_1111);
      check_val("post_rst_timer", timer_out, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
